// File: rtl/regbus_pkg.sv
// Shared types for the register-bus scheduler: FSM states, the latched
// command and the register index width helper.
package regbus_pkg;

    localparam int IDX_MAX = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WRITE,
        TURN,
        CLEAR
    } state_t;

    typedef struct packed {
        logic               clr;
        logic [IDX_MAX-1:0] src;
        logic [IDX_MAX-1:0] dst;
    } cmd_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request above i_last
// wins, otherwise the lowest request wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [GW-1:0]   i_last,
    output logic [NREQ-1:0] o_gnt,
    output logic [GW-1:0]   o_id
);

    logic [NREQ-1:0] w_hi;
    logic [NREQ-1:0] w_pick;

    always_comb begin
        w_hi = '0;
        for (int i = 0; i < NREQ; i++)
            w_hi[i] = i_req[i] && (32'(i) > 32'(i_last));
        w_pick = (|w_hi) ? w_hi : i_req;
        o_gnt  = '0;
        o_id   = '0;
        // Scan downwards so the lowest eligible index is kept.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
                o_id     = GW'(i);
            end
        end
    end

endmodule

// File: rtl/regbus_sched.sv
// Shared 8-bit register bus scheduler: round-robin command intake and
// drive/write/turnaround sequencing of one-hot register strobes.
module regbus_sched
    import regbus_pkg::*;
#(
    parameter int  NREG = 4,
    parameter int  NREQ = 2,
    parameter int  IDW  = idx_w(NREG),
    localparam int GW   = idx_w(NREQ)
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*IDW-1:0] req_src,
    input  logic [NREQ*IDW-1:0] req_dst,
    input  logic [NREQ-1:0]     req_clr,
    output logic [NREG-1:0]     oa,
    output logic [NREG-1:0]     wa,
    output logic [NREG-1:0]     clr,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [GW-1:0]       grant_id
);

    state_t          r_state;
    cmd_t            r_cmd;
    logic [GW-1:0]   r_last;
    logic [GW-1:0]   r_gid;
    logic [NREG-1:0] r_oa;
    logic [NREG-1:0] r_wa;
    logic [NREG-1:0] r_clr;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_gnt;
    logic [GW-1:0]   w_gid;
    logic            w_acc;
    cmd_t            w_cmd;
    cmd_t            w_ncmd;
    state_t          w_nstate;
    logic            w_ok;
    logic            w_bad;

    function automatic logic [NREG-1:0] dec(input logic [IDX_MAX-1:0] x);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++)
            v[i] = (32'(x) == 32'(i));
        return v;
    endfunction

    function automatic logic in_range(input logic [IDX_MAX-1:0] x);
        return 32'(x) < 32'(NREG);
    endfunction

    assign w_req = (r_state == IDLE) ? req_valid : '0;

    rr_arbiter #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_arb (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_id   (w_gid)
    );

    assign req_ready = w_gnt;
    assign w_acc     = |w_gnt;

    always_comb begin
        w_cmd = '0;
        for (int g = 0; g < NREQ; g++) begin
            if (w_gnt[g]) begin
                w_cmd.clr = req_clr[g];
                w_cmd.src = IDX_MAX'(req_src[g*IDW +: IDW]);
                w_cmd.dst = IDX_MAX'(req_dst[g*IDW +: IDW]);
            end
        end
    end

    // Degenerate and out-of-range commands never leave IDLE.
    always_comb begin
        w_nstate = r_state;
        w_ncmd   = r_cmd;
        w_ok     = 1'b0;
        w_bad    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_acc) begin
                    w_ncmd = w_cmd;
                    if (w_cmd.clr) begin
                        w_bad = !in_range(w_cmd.dst);
                        if (!w_bad)
                            w_nstate = CLEAR;
                    end else begin
                        w_bad = !in_range(w_cmd.src) || !in_range(w_cmd.dst);
                        if (!w_bad) begin
                            if (w_cmd.src == w_cmd.dst)
                                w_ok = 1'b1;
                            else
                                w_nstate = DRIVE;
                        end
                    end
                end
            end
            DRIVE:   w_nstate = WRITE;
            WRITE:   w_nstate = TURN;
            default: w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_cmd   <= '0;
            r_last  <= GW'(NREQ - 1);
            r_gid   <= '0;
            r_oa    <= '0;
            r_wa    <= '0;
            r_clr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cmd   <= w_ncmd;
            if (w_acc) begin
                r_last <= w_gid;
                r_gid  <= w_gid;
            end
            r_oa   <= (w_nstate == DRIVE || w_nstate == WRITE) ?
                      dec(w_ncmd.src) : '0;
            r_wa   <= (w_nstate == WRITE) ? dec(w_ncmd.dst) : '0;
            r_clr  <= (w_nstate == CLEAR && w_ncmd.clr) ?
                      dec(w_ncmd.dst) : '0;
            r_busy <= (w_nstate != IDLE);
            r_done <= (w_nstate == TURN) || (w_nstate == CLEAR) || w_ok;
            r_err  <= w_bad;
        end
    end

    assign oa       = r_oa;
    assign wa       = r_wa;
    assign clr      = r_clr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign grant_id = r_gid;

endmodule

// File: tb/tb_regbus_sched.sv
// Random and directed traffic for regbus_sched, checked by a scoreboard
// fed from a command-level model of the bus scheduler.
`timescale 1ns/1ps
module tb_regbus_sched;

    localparam int NREG = 4;
    localparam int NREQ = 2;
    localparam int IDW  = 2;

    typedef struct {
        int kind;
        int gid;
        int src;
        int dst;
        int acc;
    } exp_t;

    localparam int K_MOVE = 0;
    localparam int K_CLR  = 1;
    localparam int K_NOP  = 2;
    localparam int K_ERR  = 3;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*IDW-1:0] req_src;
    logic [NREQ*IDW-1:0] req_dst;
    logic [NREQ-1:0]     req_clr;
    logic [NREG-1:0]     oa;
    logic [NREG-1:0]     wa;
    logic [NREG-1:0]     clr;
    logic                busy;
    logic                done;
    logic                err;
    logic [0:0]          grant_id;

    regbus_sched #(.NREG(NREG), .NREQ(NREQ)) u_dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_clr   (req_clr),
        .oa        (oa),
        .wa        (wa),
        .clr       (clr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .grant_id  (grant_id)
    );

    logic [1:0] v3;
    logic [1:0] rdy3;
    logic [3:0] s3;
    logic [3:0] d3;
    logic [1:0] c3;
    logic [2:0] oa3;
    logic [2:0] wa3;
    logic [2:0] cl3;
    logic       busy3;
    logic       done3;
    logic       err3;
    logic [0:0] g3;

    regbus_sched #(.NREG(3), .NREQ(2)) u_dut3 (
        .clk       (clk),
        .clr_n     (clr_n),
        .req_valid (v3),
        .req_ready (rdy3),
        .req_src   (s3),
        .req_dst   (d3),
        .req_clr   (c3),
        .oa        (oa3),
        .wa        (wa3),
        .clr       (cl3),
        .busy      (busy3),
        .done      (done3),
        .err       (err3),
        .grant_id  (g3)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [NREG-1:0] oh(int i);
        return NREG'(1) << i;
    endfunction

    function automatic int rr_pick(logic [NREQ-1:0] v, int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Bus-attached registers, driven only by the scheduler's strobes.
    logic [7:0] seed [NREG];
    logic [7:0] bank [NREG];
    logic [7:0] m_reg [NREG];
    logic [7:0] bus_v;
    logic       seeded = 1'b0;

    always_comb begin
        bus_v = '0;
        for (int i = 0; i < NREG; i++)
            if (oa[i]) bus_v = bus_v | bank[i];
    end

    always @(posedge clk) begin
        if (!seeded) begin
            seeded <= 1'b1;
            for (int i = 0; i < NREG; i++) bank[i] <= seed[i];
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wa[i]) bank[i] <= bus_v;
                else if (clr[i]) bank[i] <= 8'h00;
            end
        end
    end

    exp_t q[$];
    int   m_last;
    int   m_free;
    int   m_acc;
    int   m_busy_end;

    logic hv [NREQ];
    logic hc [NREQ];
    int   hs [NREQ];
    int   hd [NREQ];

    // Monitor: pops one expectation per done/err pulse.
    int         n_oa = 0;
    int         n_wa = 0;
    int         n_clr = 0;
    logic       regchk = 1'b0;
    logic [3:0] prev_oa = '0;

    always @(negedge clk) begin : mon
        exp_t h;
        if (!clr_n) begin
            n_oa    = 0;
            n_wa    = 0;
            n_clr   = 0;
            regchk  = 1'b0;
            prev_oa = '0;
        end else begin
            if (regchk) begin
                for (int i = 0; i < NREG; i++)
                    chk("reg_value", 32'(bank[i]), 32'(m_reg[i]));
                regchk = 1'b0;
            end
            chk("oa_onehot", 32'($countones(oa) <= 1), 1);
            chk("wa_onehot", 32'($countones(wa) <= 1), 1);
            chk("clr_onehot", 32'($countones(clr) <= 1), 1);
            chk("busy", 32'(busy), 32'(cyc > m_acc && cyc <= m_busy_end));
            if (wa != '0)
                chk("wa_after_oa", 32'(prev_oa != '0), 1);
            if (q.size() == 0) begin
                chk("orphan_output", 32'(|{oa, wa, clr, done, err}), 0);
            end else begin
                h = q[0];
                if (oa != '0) begin
                    chk("oa_value", 32'(oa), 32'(oh(h.src)));
                    n_oa++;
                end
                if (wa != '0) begin
                    chk("wa_value", 32'(wa), 32'(oh(h.dst)));
                    n_wa++;
                end
                if (clr != '0) begin
                    chk("clr_value", 32'(clr), 32'(oh(h.dst)));
                    n_clr++;
                end
                if (done || err) begin
                    chk("done_err_excl", 32'(done && err), 0);
                    chk("resp_is_err", 32'(err), 32'(h.kind == K_ERR));
                    chk("grant_id", 32'(grant_id), 32'(h.gid));
                    chk("latency", 32'(cyc - h.acc), (h.kind == K_MOVE) ? 3 : 1);
                    chk("oa_cycles", 32'(n_oa), (h.kind == K_MOVE) ? 2 : 0);
                    chk("wa_cycles", 32'(n_wa), (h.kind == K_MOVE) ? 1 : 0);
                    chk("clr_cycles", 32'(n_clr), (h.kind == K_CLR) ? 1 : 0);
                    if (h.kind == K_MOVE) m_reg[h.dst] = m_reg[h.src];
                    if (h.kind == K_CLR) m_reg[h.dst] = 8'h00;
                    regchk = 1'b1;
                    void'(q.pop_front());
                    n_oa  = 0;
                    n_wa  = 0;
                    n_clr = 0;
                end
            end
            prev_oa = oa;
        end
    end

    task automatic send(int r, logic c, int s, int d);
        hv[r] = 1'b1;
        hc[r] = c;
        hs[r] = s;
        hd[r] = d;
    endtask

    // One cycle: apply held requests, predict the grant, push the outcome.
    task automatic step(output int acc_id);
        logic [NREQ-1:0] exp_rdy;
        int win;
        exp_t e;
        @(posedge clk);
        #1;
        for (int r = 0; r < NREQ; r++) begin
            req_valid[r]           = hv[r];
            req_clr[r]             = hc[r];
            req_src[r*IDW +: IDW]  = IDW'(hs[r]);
            req_dst[r*IDW +: IDW]  = IDW'(hd[r]);
        end
        @(negedge clk);
        acc_id = -1;
        if (clr_n) begin
            win     = (cyc >= m_free) ? rr_pick(req_valid, m_last) : -1;
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (win >= 0) begin
                e.gid = win;
                e.src = hs[win];
                e.dst = hd[win];
                e.acc = cyc;
                if (hc[win])
                    e.kind = (e.dst < NREG) ? K_CLR : K_ERR;
                else if (e.src >= NREG || e.dst >= NREG)
                    e.kind = K_ERR;
                else
                    e.kind = (e.src == e.dst) ? K_NOP : K_MOVE;
                q.push_back(e);
                m_last     = win;
                m_acc      = cyc;
                m_free     = cyc + ((e.kind == K_MOVE) ? 4 : (e.kind == K_CLR) ? 2 : 1);
                m_busy_end = cyc + ((e.kind == K_MOVE) ? 3 : (e.kind == K_CLR) ? 1 : 0);
            end
            for (int r = 0; r < NREQ; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    hv[r]  = 1'b0;
                    acc_id = r;
                end
            end
        end
    endtask

    task automatic run(int n);
        int a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic wait_acc(int r);
        int a;
        int got;
        got = 0;
        for (int t = 0; t < 40 && got == 0; t++) begin
            step(a);
            if (a == r) got = 1;
        end
        chk("accept_wait", 32'(got), 1);
    endtask

    // Called at a falling edge; releases reset away from the rising edge.
    task automatic do_reset();
        #1 clr_n = 1'b0;
        q.delete();
        m_last     = NREQ - 1;
        m_free     = 0;
        m_acc      = -1;
        m_busy_end = -1;
        for (int r = 0; r < NREQ; r++) hv[r] = 1'b0;
        #1;
        chk("rst_oa", 32'(oa), 0);
        chk("rst_wa", 32'(wa), 0);
        chk("rst_clr", 32'(clr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done_err", 32'({done, err}), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 clr_n = 1'b1;
    endtask

    task automatic try3(logic c, int s, int d, logic exp_err, logic [2:0] exp_clr);
        @(posedge clk);
        #1;
        v3 = 2'b01;
        c3 = {1'b0, c};
        s3 = {2'b00, 2'(s)};
        d3 = {2'b00, 2'(d)};
        @(negedge clk);
        chk("n3_ready", 32'(rdy3), 1);
        @(posedge clk);
        #1 v3 = 2'b00;
        @(negedge clk);
        chk("n3_err", 32'(err3), 32'(exp_err));
        chk("n3_done", 32'(done3), 32'(!exp_err));
        chk("n3_oa_wa", 32'({oa3, wa3}), 0);
        chk("n3_clr", 32'(cl3), 32'(exp_clr));
        @(negedge clk);
        chk("n3_pulse_end", 32'({done3, err3, busy3}), 0);
    endtask

    initial begin
        int a;
        clr_n     = 1'b0;
        req_valid = '0;
        req_clr   = '0;
        req_src   = '0;
        req_dst   = '0;
        v3 = '0;
        c3 = '0;
        s3 = '0;
        d3 = '0;
        for (int r = 0; r < NREQ; r++) begin
            hv[r] = 1'b0;
            hc[r] = 1'b0;
            hs[r] = 0;
            hd[r] = 0;
        end
        for (int i = 0; i < NREG; i++) begin
            seed[i]  = 8'(16 * (i + 1) + $urandom_range(0, 15));
            m_reg[i] = seed[i];
        end
        m_last     = NREQ - 1;
        m_free     = 0;
        m_acc      = -1;
        m_busy_end = -1;

        #2;
        chk("rst_oa", 32'(oa), 0);
        chk("rst_wa", 32'(wa), 0);
        chk("rst_clr", 32'(clr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done_err", 32'({done, err}), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        @(negedge clk);
        #2 clr_n = 1'b1;

        send(0, 1'b0, 1, 2);
        wait_acc(0);
        run(5);

        @(negedge clk);
        do_reset();
        for (int n = 0; n < 8; n++) begin
            int got;
            got = -1;
            for (int r = 0; r < NREQ; r++)
                if (!hv[r]) send(r, 1'b0, r, 3 - r);
            for (int t = 0; t < 12 && got < 0; t++) step(got);
            chk("rr_order", 32'(got), 32'(n % 2));
        end
        for (int r = 0; r < NREQ; r++) hv[r] = 1'b0;
        run(6);

        send(1, 1'b1, 0, 3);
        wait_acc(1);
        run(3);

        send(0, 1'b0, 2, 2);
        wait_acc(0);
        run(2);

        send(0, 1'b0, 0, 3);
        wait_acc(0);
        run(2);
        chk("write_phase_wa", 32'(wa), 32'(oh(3)));
        chk("write_phase_oa", 32'(oa), 32'(oh(0)));
        do_reset();
        chk("dst_unchanged", 32'(bank[3]), 32'(m_reg[3]));
        send(1, 1'b0, 1, 0);
        send(0, 1'b0, 2, 1);
        begin
            int got;
            got = -1;
            for (int t = 0; t < 4 && got < 0; t++) step(got);
            chk("prio_after_reset", 32'(got), 0);
        end
        for (int r = 0; r < NREQ; r++) hv[r] = 1'b0;
        run(8);

        try3(1'b0, 0, 3, 1'b1, 3'b000);
        try3(1'b1, 0, 3, 1'b1, 3'b000);
        try3(1'b1, 3, 1, 1'b0, 3'b010);
        try3(1'b0, 1, 1, 1'b0, 3'b000);

        for (int i = 0; i < 10000; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!hv[r] && $urandom_range(0, 3) == 0)
                    send(r, 1'($urandom_range(0, 3) == 0),
                         $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1));
                else if (hv[r] && $urandom_range(0, 31) == 0)
                    hv[r] = 1'b0;
            end
            step(a);
        end

        for (int r = 0; r < NREQ; r++) hv[r] = 1'b0;
        for (int t = 0; t < 20 && q.size() != 0; t++) step(a);
        run(2);
        chk("drain_empty", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
